// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: lets NREQ requesters take turns using one external
// bit-serial sequence detector. A round-robin arbiter picks a winner and
// captures its word. The detector is then cleared for one cycle and the
// word is shifted in MSB-first. The detector's hits are counted and the
// total is returned to the winner with a one-cycle done strobe.

module seq_det_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] word_in,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  done,
  output logic [ID_W-1:0]       done_id,
  output logic [CNT_W-1:0]      match_count,
  output logic                  det_reset,
  output logic                  det_data_in,
  input  logic                  det_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [NREQ-1:0]  r_grant;
  logic [WIDTH-1:0] r_shiftReg;
  logic [CNT_W-1:0] r_bitCnt;
  logic [CNT_W-1:0] r_hitCnt;
  logic [ID_W-1:0]  r_rrPtr;
  logic [ID_W-1:0]  r_doneId;
  logic [CNT_W-1:0] r_matchCount;

  logic             w_anyReq;
  logic [ID_W-1:0]  w_winner;
  logic [ID_W:0]    w_sum;
  logic [NREQ-1:0]  w_winnerOneHot;
  logic [WIDTH-1:0] w_winnerWord;
  logic             w_lastBit;
  logic             w_flush;

  // Round-robin search: scan from the slot after the last winner, wrapping
  // modulo NREQ, and take the first requester found.
  always_comb begin
    w_anyReq = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, r_rrPtr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NREQ)) begin
        w_sum = w_sum - (ID_W+1)'(NREQ);
      end
      if (!w_anyReq && req[w_sum[ID_W-1:0]]) begin
        w_anyReq = 1'b1;
        w_winner = w_sum[ID_W-1:0];
      end
    end
  end

  assign w_winnerOneHot = NREQ'(1) << w_winner;
  assign w_winnerWord   = word_in[int'(w_winner)*WIDTH +: WIDTH];
  assign w_lastBit      = (r_bitCnt == CNT_W'(WIDTH-1));

  // State register; an asynchronous reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: FLUSH, DRAIN and DONE each last one cycle, and SHIFT
  // lasts WIDTH cycles.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_anyReq) w_nextState = S_FLUSH;
      S_FLUSH: w_nextState = S_SHIFT;
      S_SHIFT: if (w_lastBit) w_nextState = S_DRAIN;
      S_DRAIN: w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Decoded outputs: the detector sees data only during SHIFT.
  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    w_flush     = (r_state == S_FLUSH);
    det_data_in = 1'b0;
    if (r_state == S_SHIFT) begin
      det_data_in = r_shiftReg[WIDTH-1];
    end
  end

  // The detector is also held in reset while this block is in reset.
  assign det_reset   = reset | w_flush;
  assign grant       = r_grant;
  assign done_id     = r_doneId;
  assign match_count = r_matchCount;

  // Datapath. At grant, the word is captured and the pointer advances.
  // During SHIFT, bits are shifted out and hits are counted. det_out lags the
  // driven bit by one cycle, so the first SHIFT cycle is ignored. The hit for
  // the last bit appears during DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant      <= '0;
      r_shiftReg   <= '0;
      r_bitCnt     <= '0;
      r_hitCnt     <= '0;
      r_rrPtr      <= ID_W'(NREQ-1);
      r_doneId     <= '0;
      r_matchCount <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_grant    <= w_winnerOneHot;
            r_shiftReg <= w_winnerWord;
            r_hitCnt   <= '0;
            r_rrPtr    <= w_winner;
          end
        end
        S_FLUSH: begin
          r_bitCnt <= '0;
        end
        S_SHIFT: begin
          r_shiftReg <= {r_shiftReg[WIDTH-2:0], 1'b0};
          r_bitCnt   <= r_bitCnt + CNT_W'(1);
          if ((r_bitCnt != '0) && det_out) begin
            r_hitCnt <= r_hitCnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          r_matchCount <= r_hitCnt + CNT_W'(det_out);
          r_doneId     <= r_rrPtr;
        end
        S_DONE: begin
          r_grant <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Testbench for seq_det_scheduler. A behavioural overlapping-"101" Moore
// detector is attached to the DUT. Each operation pushes its expected
// {done_id, match_count} into a queue, and a monitor pops and compares the
// entry whenever done fires.

module tb_seq_det_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int ID_W  = 2;

  logic                  clk   = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wordIn;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  done;
  logic [ID_W-1:0]       doneId;
  logic [CNT_W-1:0]      matchCount;
  logic                  detReset;
  logic                  detDataIn;
  logic                  detOut;

  typedef struct {
    int id;
    int cnt;
  } expT;

  expT sbQ[$];
  int  total = 0;
  int  bad   = 0;

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  seq_det_scheduler #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .ID_W (ID_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .word_in    (wordIn),
    .grant      (grant),
    .busy       (busy),
    .done       (done),
    .done_id    (doneId),
    .match_count(matchCount),
    .det_reset  (detReset),
    .det_data_in(detDataIn),
    .det_out    (detOut)
  );

  // Detector model: overlapping "101", Moore output. The output goes high
  // the cycle after the third bit of a match is sampled.
  logic [1:0] detHist;
  always @(posedge clk or posedge detReset) begin
    if (detReset) begin
      detHist <= 2'b00;
      detOut  <= 1'b0;
    end else begin
      detOut  <= (detHist == 2'b10) && detDataIn;
      detHist <= {detHist[0], detDataIn};
    end
  end

  // One comparison: bump the counters and report a mismatch.
  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Queue up the expected result of an operation about to be granted.
  task automatic expectDone(input int id, input int cnt);
    expT e;
    e.id  = id;
    e.cnt = cnt;
    sbQ.push_back(e);
  endtask

  // Drive inputs 1 ns after a rising edge, well clear of sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a request pattern.
  task automatic applyStimulus(input logic [NREQ-1:0] r);
    req = r;
  endtask

  // Follow one operation: check the grant pattern and the number of idle
  // cycles before it appears. Then check that grant lasts FLUSH + WIDTH +
  // DRAIN + DONE cycles, that done is in the last of those cycles, and that
  // det_reset is high for exactly one of them.
  task automatic observeOp(input logic [NREQ-1:0] expGrant, input int expGap,
                           input string tag);
    int waitCnt = 0;
    int gCycles = 0;
    int doneAt  = 0;
    int drCycles = 0;
    @(negedge clk);
    while (grant == '0 && waitCnt < 20) begin
      waitCnt++;
      @(negedge clk);
    end
    checkOutput({tag, "_grant"}, int'(grant), int'(expGrant));
    checkOutput({tag, "_gap"}, waitCnt, expGap);
    while (grant != '0 && gCycles < 40) begin
      gCycles++;
      if (done) doneAt = gCycles;
      if (detReset) drCycles++;
      @(negedge clk);
    end
    checkOutput({tag, "_grantLen"}, gCycles, WIDTH + 3);
    checkOutput({tag, "_doneCycle"}, doneAt, WIDTH + 3);
    checkOutput({tag, "_detResetCycles"}, drCycles, 1);
  endtask

  // Scoreboard monitor: whenever done is high, compare it against the
  // oldest queued expectation. A done with nothing queued is an error.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done: got done_id=%0d match_count=%0d expected no done",
                   doneId, matchCount);
        end else begin
          e = sbQ.pop_front();
          checkOutput("done_id", int'(doneId), e.id);
          checkOutput("match_count", int'(matchCount), e.cnt);
        end
      end
    end
  end

  // Watchdog so that a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    req    = '0;
    wordIn = '0;

    // Test 1: reset values, then a single 0xAA operation for requester 0.
    repeat (2) @(negedge clk);
    checkOutput("rst_grant", int'(grant), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_done_id", int'(doneId), 0);
    checkOutput("rst_match_count", int'(matchCount), 0);
    checkOutput("rst_det_data_in", int'(detDataIn), 0);
    checkOutput("rst_det_reset", int'(detReset), 1);
    tick();
    reset = 1'b0;
    wordIn[7:0] = 8'hAA;
    expectDone(0, 3);
    applyStimulus(4'b0001);
    fork
      begin
        repeat (3) tick();
        req = 4'b0000;
      end
    join_none
    observeOp(4'b0001, 1, "t1");

    // Test 2: 0xF0 gives no hits. A held request then re-wins with 0xB5,
    // one cycle after DONE.
    tick();
    wordIn[7:0] = 8'hF0;
    expectDone(0, 0);
    expectDone(0, 3);
    applyStimulus(4'b0001);
    fork
      begin
        repeat (3) tick();
        wordIn[7:0] = 8'hB5;
        repeat (12) tick();
        req = 4'b0000;
      end
    join_none
    observeOp(4'b0001, 1, "t2a");
    observeOp(4'b0001, 0, "t2b");

    // Test 3: after a fresh reset, all four requesters hold their requests.
    // Grants rotate 0,1,2,3,0.
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    wordIn = {NREQ{8'hAA}};
    expectDone(0, 3);
    expectDone(1, 3);
    expectDone(2, 3);
    expectDone(3, 3);
    expectDone(0, 3);
    applyStimulus(4'b1111);
    fork
      begin
        repeat (55) tick();
        req = 4'b0000;
      end
    join_none
    for (int i = 0; i < 5; i++) begin
      observeOp(4'b0001 << (i % NREQ), (i == 0) ? 1 : 0, $sformatf("t3_%0d", i));
    end

    // Test 4: the word is captured at grant, and dropping req does not abort.
    tick();
    expectDone(2, 3);
    applyStimulus(4'b0100);
    fork
      begin
        repeat (3) tick();
        wordIn[23:16] = 8'h00;
        req = 4'b0000;
      end
    join_none
    observeOp(4'b0100, 1, "t4");

    // Test 5: reset during the fourth SHIFT cycle drops everything with no
    // done. Requester 2 then wins over requester 3 because the pointer
    // restarts.
    tick();
    wordIn[7:0] = 8'hFF;
    applyStimulus(4'b0001);
    repeat (5) tick();
    checkOutput("t5_busy_before_reset", int'(busy), 1);
    checkOutput("t5_data_before_reset", int'(detDataIn), 1);
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_grant", int'(grant), 0);
    checkOutput("t5_rst_busy", int'(busy), 0);
    checkOutput("t5_rst_det_data_in", int'(detDataIn), 0);
    checkOutput("t5_rst_det_reset", int'(detReset), 1);
    checkOutput("t5_rst_done", int'(done), 0);
    tick();
    tick();
    reset = 1'b0;
    wordIn[23:16] = 8'hAA;
    wordIn[31:24] = 8'hAA;
    expectDone(2, 3);
    applyStimulus(4'b1100);
    fork
      begin
        repeat (3) tick();
        req = 4'b0000;
      end
    join_none
    observeOp(4'b0100, 1, "t5");

    // Test 6: requester 1 finishes 0xFF with no hits. It then re-requests
    // alongside requester 3, and requester 3 goes next.
    tick();
    wordIn[15:8]  = 8'hFF;
    wordIn[31:24] = 8'hAA;
    expectDone(1, 0);
    expectDone(3, 3);
    applyStimulus(4'b0010);
    fork
      begin
        repeat (3) tick();
        req = 4'b1010;
        repeat (12) tick();
        req = 4'b0000;
      end
    join_none
    observeOp(4'b0010, 1, "t6a");
    observeOp(4'b1000, 0, "t6b");

    // Every queued expectation must have been consumed by a done.
    repeat (5) @(negedge clk);
    checkOutput("sb_left", sbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
